// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD drawing engine: panel geometry defaults,
// RGB565 colour constants and the rectangle-fill state encoding.
package lcd_pkg;

    localparam int LCD_W_DEF = 132;
    localparam int LCD_H_DEF = 162;

    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLIP = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rect_clip.sv
// Clips a latched rectangle to the panel: exclusive x/y end bounds, unclipped
// right/bottom edge coordinates and the empty flag, all in 9-bit arithmetic.
module lcd_rect_clip
    import lcd_pkg::*;
#(
    parameter int LCD_W = LCD_W_DEF,
    parameter int LCD_H = LCD_H_DEF
) (
    input  logic [7:0] x0,
    input  logic [7:0] y0,
    input  logic [7:0] w,
    input  logic [7:0] h,
    output logic [8:0] x_end,
    output logic [8:0] y_end,
    output logic [8:0] x_right,
    output logic [8:0] y_bottom,
    output logic       empty
);

    localparam logic [8:0] PANEL_W = 9'(LCD_W);
    localparam logic [8:0] PANEL_H = 9'(LCD_H);

    logic [8:0] x_sum;
    logic [8:0] y_sum;

    assign x_sum = {1'b0, x0} + {1'b0, w};
    assign y_sum = {1'b0, y0} + {1'b0, h};

    assign x_end = min9(x_sum, PANEL_W);
    assign y_end = min9(y_sum, PANEL_H);

    // Meaningless when w or h is zero, but those commands never reach FILL.
    assign x_right  = x_sum - 9'd1;
    assign y_bottom = y_sum - 9'd1;

    assign empty = (w == 8'd0) || (h == 8'd0) ||
                   ({1'b0, x0} >= PANEL_W) || ({1'b0, y0} >= PANEL_H);

endmodule

// File: rtl/lcd_rect_fill.sv
// Rectangle drawing engine: accepts a command, clips it to the panel and
// writes a solid or outlined RGB565 rectangle one pixel per accepted write.
module lcd_rect_fill
    import lcd_pkg::*;
#(
    parameter int LCD_W = LCD_W_DEF,
    parameter int LCD_H = LCD_H_DEF
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x0,
    input  logic [7:0]  cmd_y0,
    input  logic [7:0]  cmd_w,
    input  logic [7:0]  cmd_h,
    input  logic [15:0] cmd_color,
    input  logic        cmd_outline,
    output logic        fb_we,
    output logic [7:0]  fb_addr_x,
    output logic [7:0]  fb_addr_y,
    output logic [15:0] fb_wdata,
    input  logic        fb_wready,
    output logic        busy,
    output logic        done
);

    logic [1:0]  state;
    logic [7:0]  x0_q, y0_q, w_q, h_q;
    logic        outline_q;
    logic [15:0] color_q;
    logic [7:0]  x_q, y_q;

    logic [8:0]  x_end, y_end, x_right, y_bottom;
    logic        empty;

    lcd_rect_clip #(
        .LCD_W (LCD_W),
        .LCD_H (LCD_H)
    ) u_clip (
        .x0       (x0_q),
        .y0       (y0_q),
        .w        (w_q),
        .h        (h_q),
        .x_end    (x_end),
        .y_end    (y_end),
        .x_right  (x_right),
        .y_bottom (y_bottom),
        .empty    (empty)
    );

    logic accept;
    logic pixel_done;
    logic last_col;
    logic last_row;
    logic interior_row;
    logic row_end;
    logic [7:0] x_step;

    assign accept     = cmd_valid && cmd_ready;
    assign pixel_done = fb_we && fb_wready;

    assign last_col = (({1'b0, x_q} + 9'd1) == x_end);
    assign last_row = (({1'b0, y_q} + 9'd1) == y_end);

    // Interior rows of an outline only carry the left and right edge pixels;
    // a 1-wide or 1-high outline has no interior and fills solid.
    assign interior_row = outline_q && (w_q > 8'd1) && (h_q > 8'd1) &&
                          (y_q != y0_q) && ({1'b0, y_q} != y_bottom);

    assign row_end = last_col || (interior_row && (x_right >= x_end));
    assign x_step  = interior_row ? x_right[7:0] : (x_q + 8'd1);

    assign cmd_ready = (state == ST_IDLE) && !rst_in;
    assign fb_we     = (state == ST_FILL);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fb_addr_x = x_q;
    assign fb_addr_y = y_q;
    assign fb_wdata  = color_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            color_q <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        color_q <= cmd_color;
                        state   <= ST_CLIP;
                    end
                end
                ST_CLIP: begin
                    if (empty) begin
                        state <= ST_DONE;
                    end else begin
                        x_q   <= x0_q;
                        y_q   <= y0_q;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Position advances only on a completed write, so a stall
                    // holds address and data exactly where they are.
                    if (pixel_done) begin
                        if (row_end) begin
                            x_q <= x0_q;
                            if (last_row) begin
                                state <= ST_DONE;
                            end else begin
                                y_q <= y_q + 8'd1;
                            end
                        end else begin
                            x_q <= x_step;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Geometry is only consumed after CLIP, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x0_q      <= cmd_x0;
            y0_q      <= cmd_y0;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            outline_q <= cmd_outline;
        end
    end

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Directed bench for lcd_rect_fill: a pixel-list model of each rectangle is
// compared against every completed frame-buffer write, plus timing checks.
module tb_lcd_rect_fill;
    import lcd_pkg::*;

    logic        clk;
    logic        rst_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [15:0] cmd_color;
    logic        cmd_outline;
    logic        fb_we;
    logic [7:0]  fb_addr_x, fb_addr_y;
    logic [15:0] fb_wdata;
    logic        fb_wready;
    logic        busy;
    logic        done;

    lcd_rect_fill dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .cmd_outline (cmd_outline),
        .fb_we       (fb_we),
        .fb_addr_x   (fb_addr_x),
        .fb_addr_y   (fb_addr_y),
        .fb_wdata    (fb_wdata),
        .fb_wready   (fb_wready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t        exp_q[$];
    pix_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Every pixel of the unclipped rectangle, kept if on-panel and, in outline
    // mode, on one of the four unclipped edges; raster order.
    function automatic void build_model(input int x0, input int y0, input int w, input int h,
                                        input int c, input bit outline);
        exp_q.delete();
        for (int yy = y0; yy < y0 + h; yy++) begin
            for (int xx = x0; xx < x0 + w; xx++) begin
                if (xx < 132 && yy < 162 &&
                    (!outline || xx == x0 || xx == x0 + w - 1 || yy == y0 || yy == y0 + h - 1))
                    exp_q.push_back('{xx, yy, c});
            end
        end
    endfunction

    function automatic logic [31:0] pack_pix(input pix_t p);
        return {p.x[7:0], p.y[7:0], p.c[15:0]};
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst_in) begin
            if (stall_prev) begin
                check("stall_hold", {fb_addr_x, fb_addr_y, fb_wdata}, stall_val);
                check("stall_we", 32'(fb_we), 32'd1);
            end
            if (fb_we && fb_wready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h, expected no write",
                             {fb_addr_x, fb_addr_y, fb_wdata});
                end else begin
                    cur = exp_q.pop_front();
                    check("pixel", {fb_addr_x, fb_addr_y, fb_wdata}, pack_pix(cur));
                end
            end
            stall_prev = fb_we && !fb_wready;
            stall_val  = {fb_addr_x, fb_addr_y, fb_wdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic run_cmd(input string tag, input int x0, input int y0, input int w, input int h,
                           input int c, input bit outline, input int exp_writes,
                           input int stall_x, input int stall_n, input int rst_after);
        int cyc, writes, first_we, done_cyc, stalls_left, seen;
        build_model(x0, y0, w, h, c, outline);
        check({tag, "_model_size"}, 32'(exp_q.size()), 32'(exp_writes));
        @(posedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_x0      = x0[7:0];
        cmd_y0      = y0[7:0];
        cmd_w       = w[7:0];
        cmd_h       = h[7:0];
        cmd_color   = c[15:0];
        cmd_outline = outline;
        fb_wready   = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble the command inputs: they must be ignored once accepted.
        cmd_valid   = 1'b0;
        cmd_x0      = 8'h55;
        cmd_y0      = 8'hAA;
        cmd_w       = 8'h03;
        cmd_h       = 8'h07;
        cmd_color   = 16'h1234;
        cmd_outline = ~outline;
        cyc = 1; writes = 0; first_we = -1; done_cyc = -1; stalls_left = stall_n;
        while (cyc < 300) begin
            fb_wready = 1'b1;
            if (fb_we && stall_x >= 0 && fb_addr_x == stall_x[7:0] && stalls_left > 0) begin
                fb_wready = 1'b0;
                stalls_left--;
            end
            @(negedge clk);
            if (cyc == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (fb_we && first_we < 0) first_we = cyc;
            if (fb_we && fb_wready) writes++;
            if (done) begin
                done_cyc = cyc;
                check({tag, "_busy_done"}, 32'(busy), 32'd1);
                break;
            end
            if (rst_after > 0 && writes == rst_after) break;
            @(posedge clk); #1;
            cyc++;
        end
        if (rst_after > 0) begin
            @(posedge clk); #1;
            rst_in = 1'b1;
            @(negedge clk);
            check({tag, "_ready_in_rst"}, 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            rst_in = 1'b0;
            @(negedge clk);
            check({tag, "_we_after_rst"}, 32'(fb_we), 32'd0);
            check({tag, "_busy_after_rst"}, 32'(busy), 32'd0);
            check({tag, "_done_after_rst"}, 32'(done), 32'd0);
            check({tag, "_ready_after_rst"}, 32'(cmd_ready), 32'd1);
            check({tag, "_writes_before_rst"}, 32'(exp_writes - exp_q.size()), 32'(rst_after));
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (fb_we || done) seen++;
            end
            check({tag, "_quiet_after_rst"}, 32'(seen), 32'd0);
            exp_q.delete();
            return;
        end
        check({tag, "_writes"}, 32'(writes), 32'(exp_writes));
        check({tag, "_first_we"}, 32'(first_we), (exp_writes > 0) ? 32'd2 : 32'hFFFF_FFFF);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(2 + exp_writes + stall_n));
        check({tag, "_model_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_in      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_x0      = 8'd0;
        cmd_y0      = 8'd0;
        cmd_w       = 8'd0;
        cmd_h       = 8'd0;
        cmd_color   = 16'd0;
        cmd_outline = 1'b0;
        fb_wready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_addr_data", {fb_addr_x, fb_addr_y, fb_wdata}, 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk_en = 1'b1;

        // Hand-computed pins on the model itself.
        build_model(10, 20, 2, 2, 'hF800, 1'b0);
        check("pin_solid_3rd", pack_pix(exp_q[2]), {8'd10, 8'd20 + 8'd1, RGB_RED});
        build_model(130, 160, 10, 5, 'h07E0, 1'b0);
        check("pin_clip_last", pack_pix(exp_q[3]), {8'd131, 8'd161, RGB_GREEN});
        build_model(0, 0, 4, 3, 'h07E0, 1'b1);
        check("pin_outline_5th", pack_pix(exp_q[4]), {8'd0, 8'd1, RGB_GREEN});
        check("pin_outline_6th", pack_pix(exp_q[5]), {8'd3, 8'd1, RGB_GREEN});
        exp_q.delete();

        run_cmd("solid2x2",    10,  20,  2, 2, 'hF800, 1'b0,  4, -1, 0, 0);
        run_cmd("clip_corner", 130, 160, 10, 5, 'h001F, 1'b0, 4, -1, 0, 0);
        run_cmd("empty_w0",    5,   5,   0, 3, 'hFFFF, 1'b0,  0, -1, 0, 0);
        run_cmd("empty_x132",  132, 5,   4, 3, 'hFFFF, 1'b0,  0, -1, 0, 0);
        run_cmd("empty_y162",  5,   162, 4, 3, 'hFFFF, 1'b0,  0, -1, 0, 0);
        run_cmd("empty_h0",    5,   5,   4, 0, 'hFFFF, 1'b0,  0, -1, 0, 0);
        run_cmd("outline4x3",  0,   0,   4, 3, 'h07E0, 1'b1, 10, -1, 0, 0);
        run_cmd("outline_rclip", 128, 10, 6, 4, 'hFFE0, 1'b1, 10, -1, 0, 0);
        run_cmd("outline_w1",  50,  50,  1, 3, 'h1F1F, 1'b1,  3, -1, 0, 0);
        run_cmd("outline_h1",  60,  70,  5, 1, 'h00FF, 1'b1,  5, -1, 0, 0);
        run_cmd("stall3x1",    0,   40,  3, 1, 'hA5A5, 1'b0,  3,  1, 3, 0);
        run_cmd("rst_mid",     20,  30,  8, 8, 'h0F0F, 1'b0, 64, -1, 0, 5);
        run_cmd("after_rst",   100, 100, 3, 2, 'hF800, 1'b0,  6, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
